// File: rtl/sram_to_sbus_pkg.sv
// sram_to_sbus shared types.
// Size/lane decode and write-buffer entry layout.
package sram_to_sbus_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } sbus_size_t;

    typedef enum logic [1:0] {
        IDLE,
        LD_WAIT,
        RD_REQ,
        RD_DATA
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        sbus_size_t  size;
        logic [31:0] data;
    } wbuf_entry_t;

    typedef struct packed {
        logic       legal;
        sbus_size_t size;
        logic [1:0] lane;
    } be_dec_t;

    function automatic be_dec_t be_to_size(
        input logic [3:0] be,
        input logic [1:0] addr
    );
        be_dec_t d;
        d.legal = 1'b1;
        d.size  = BYTE;
        d.lane  = 2'd0;
        case (be)
            4'b0001: d.lane = 2'd0;
            4'b0010: d.lane = 2'd1;
            4'b0100: d.lane = 2'd2;
            4'b1000: d.lane = 2'd3;
            4'b0011: d.size = HALF;
            4'b1100: begin
                d.size = HALF;
                d.lane = 2'd2;
            end
            4'b1111: d.size = WORD;
            default: d.legal = 1'b0;
        endcase
        // The address must point at the first enabled lane.
        d.legal = d.legal & (addr == d.lane);
        return d;
    endfunction

    function automatic logic [31:0] size_mask(
        input sbus_size_t s
    );
        case (s)
            BYTE:    return 32'h0000_00ff;
            HALF:    return 32'h0000_ffff;
            default: return 32'hffff_ffff;
        endcase
    endfunction

endpackage

// File: rtl/sram_to_sbus_if.sv
// sbus bus bundle.
// Master drives request fields, slave returns stall and read data.
interface sram_to_sbus_if
    import sram_to_sbus_pkg::*;
;
    logic        en;
    logic        we;
    sbus_size_t  size;
    logic [31:0] addr;
    logic [31:0] data_w;
    logic [31:0] data_r;
    logic        stall;

    modport master (
        output en, we, size, addr, data_w,
        input  data_r, stall
    );

    modport slave (
        input  en, we, size, addr, data_w,
        output data_r, stall
    );
endinterface

// File: rtl/sram_to_sbus_write_buffer.sv
// Posted-store FIFO for sram_to_sbus.
// Extra pointer MSB tells full from empty.
module sram_to_sbus_write_buffer
    import sram_to_sbus_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wbuf_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  entry_t push_data,
    output logic   full,
    output logic   empty,
    output entry_t head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    entry_t      mem_q [DEPTH];
    entry_t      mem_d [DEPTH];

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointers and storage for push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer registers; reset flushes the buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage, no reset needed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/sram_to_sbus.sv
// CPU SRAM-port to sbus master bridge.
// Posts stores, drains them before any load read.
module sram_to_sbus
    import sram_to_sbus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    sram_to_sbus_if.master sbus
);
    be_dec_t     dec;
    state_t      state_q, state_d;
    logic [31:0] ld_addr_q, ld_addr_d;
    sbus_size_t  ld_size_q, ld_size_d;
    logic [1:0]  ld_lane_q, ld_lane_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_ok, ld_start, drain;
    logic        wb_push, wb_pop;
    logic        wb_full, wb_empty;
    wbuf_entry_t wb_in, wb_head;

    assign dec = be_to_size(cpu_be, cpu_addr[1:0]);

    assign cpu_rvalid = rvalid_q;
    assign cpu_rdata  = rdata_q;
    assign cpu_err    = err_q;

    // Request acceptance; a held load is retired in its rvalid cycle.
    always_comb begin
        req_ok   = cpu_req & dec.legal;
        ld_start = req_ok & ~cpu_wr &
                   (state_q == IDLE) & ~rvalid_q;
        wb_push  = req_ok & cpu_wr &
                   (state_q == IDLE) & ~wb_full;
        cpu_stall = req_ok &
                    ((state_q != IDLE) |
                     (cpu_wr ? wb_full : ~rvalid_q));
        wb_in.addr = {cpu_addr[31:2], dec.lane};
        wb_in.size = dec.size;
        wb_in.data = cpu_wdata >> {dec.lane, 3'b000};
    end

    // sbus mux: pending read wins, else drain buffer head.
    always_comb begin
        drain       = ~wb_empty &
                      ((state_q == IDLE) | (state_q == LD_WAIT));
        sbus.en     = 1'b0;
        sbus.we     = 1'b0;
        sbus.size   = BYTE;
        sbus.addr   = '0;
        sbus.data_w = '0;
        if (state_q == RD_REQ) begin
            sbus.en   = 1'b1;
            sbus.size = ld_size_q;
            sbus.addr = ld_addr_q;
        end else if (drain) begin
            sbus.en     = 1'b1;
            sbus.we     = 1'b1;
            sbus.size   = wb_head.size;
            sbus.addr   = wb_head.addr;
            sbus.data_w = wb_head.data;
        end
        wb_pop = drain & ~sbus.stall;
    end

    // Load FSM next state, pending-load latch, read return.
    always_comb begin
        state_d   = state_q;
        ld_addr_d = ld_addr_q;
        ld_size_d = ld_size_q;
        ld_lane_d = ld_lane_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        err_d     = cpu_req & ~dec.legal;
        unique case (state_q)
            IDLE: begin
                if (ld_start) begin
                    ld_addr_d = {cpu_addr[31:2], dec.lane};
                    ld_size_d = dec.size;
                    ld_lane_d = dec.lane;
                    state_d   = wb_empty ? RD_REQ : LD_WAIT;
                end
            end
            LD_WAIT: begin
                if (wb_empty) state_d = RD_REQ;
            end
            RD_REQ: begin
                if (!sbus.stall) state_d = RD_DATA;
            end
            RD_DATA: begin
                rdata_d  = (sbus.data_r & size_mask(ld_size_q))
                           << {ld_lane_q, 3'b000};
                rvalid_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            ld_addr_q <= '0;
            ld_size_q <= BYTE;
            ld_lane_q <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_addr_q <= ld_addr_d;
            ld_size_q <= ld_size_d;
            ld_lane_q <= ld_lane_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    sram_to_sbus_write_buffer #(
        .DEPTH   (DEPTH),
        .entry_t (wbuf_entry_t)
    ) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (wb_push),
        .pop       (wb_pop),
        .push_data (wb_in),
        .full      (wb_full),
        .empty     (wb_empty),
        .head      (wb_head)
    );
endmodule

// File: tb/tb_sram_to_sbus.sv
// Bench for sram_to_sbus.
// Byte-memory reference model plus sbus slave.
module tb_sram_to_sbus;
    import sram_to_sbus_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [3:0]  cpu_be = '0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        cpu_err;

    sram_to_sbus_if sbus();

    sram_to_sbus #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_wr     (cpu_wr),
        .cpu_be     (cpu_be),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_err    (cpu_err),
        .sbus       (sbus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
    } txn_t;

    txn_t       exp_q[$];
    logic [7:0] cpu_mem [16];
    logic [7:0] slv_mem [16];
    int         stall_mode = 2;
    int         cyc = 0;
    int         acc_cyc = 0;
    bit         load_waiting = 0;
    bit         err_expect = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    logic [3:0] be_tab [7] = '{4'h1, 4'h2, 4'h4, 4'h8,
                              4'h3, 4'hc, 4'hf};
    logic [1:0] lane_tab [7] = '{2'd0, 2'd1, 2'd2, 2'd3,
                                2'd0, 2'd2, 2'd0};

    always @(posedge clk) cyc++;

    task automatic check(input string tag,
                         input logic [95:0] got,
                         input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    // Legal = naturally aligned 1/2/4-byte run, addr at its first lane.
    function automatic bit legal_req(input logic [3:0] be,
                                     input logic [1:0] a,
                                     output int lo,
                                     output int n);
        logic [3:0] m;
        n  = $countones(be);
        lo = 0;
        for (int i = 3; i >= 0; i--) if (be[i]) lo = i;
        m = 4'(((1 << n) - 1) << lo);
        return (n == 1 || n == 2 || n == 4) && (be == m) &&
               (lo % n == 0) && (int'(a) == lo);
    endfunction

    // sbus slave and bus monitor.
    initial begin : slave
        bit          hold;
        logic [66:0] hold_v;
        bit          rd_next;
        logic [31:0] rdv;
        txn_t        t;
        int          nb;
        hold = 0;
        rd_next = 0;
        rdv = '0;
        sbus.stall = 1'b0;
        sbus.data_r = '0;
        forever begin
            @(negedge clk);
            rd_next = 0;
            if (!rst) begin
                hold = 0;
            end else begin
                if (hold)
                    check("sbus_hold",
                          {sbus.en, sbus.we, sbus.addr,
                           sbus.size, sbus.data_w},
                          {1'b1, hold_v});
                hold = sbus.en & sbus.stall;
                hold_v = {sbus.we, sbus.addr, sbus.size, sbus.data_w};
                if (sbus.en && !sbus.stall) begin
                    if (exp_q.size() == 0) begin
                        check("sbus_unexpected", 1, 0);
                    end else begin
                        t = exp_q.pop_front();
                        check("sbus_txn",
                              {sbus.we, sbus.addr, sbus.size,
                               sbus.we ? sbus.data_w : 32'h0},
                              {t.we, t.addr, t.size, t.data});
                        nb = 1 << int'(sbus.size);
                        if (sbus.we) begin
                            for (int k = 0; k < nb; k++)
                                slv_mem[4'(sbus.addr + k)] =
                                    sbus.data_w[8*k +: 8];
                        end else begin
                            rdv = '0;
                            for (int k = 0; k < nb; k++)
                                rdv[8*k +: 8] =
                                    slv_mem[4'(sbus.addr + k)];
                            rd_next = 1;
                            acc_cyc = cyc;
                        end
                    end
                end
                if (cpu_rvalid)
                    check("rvalid_spurious", load_waiting, 1);
                if (cpu_err)
                    check("err_spurious", err_expect, 1);
            end
            @(posedge clk);
            #1;
            sbus.stall = (stall_mode == 1) ? 1'b1 :
                         (stall_mode == 2) ? 1'b0 :
                         ($urandom % 4 == 0);
            sbus.data_r = rd_next ? rdv : $urandom;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One CPU request; starts and ends 1 time unit after posedge.
    task automatic cpu_op(input bit wr,
                          input logic [3:0] be,
                          input logic [31:0] addr,
                          input logic [31:0] wd);
        int lo, n, t;
        bit ok;
        logic [31:0] expv;
        txn_t e;
        ok = legal_req(be, addr[1:0], lo, n);
        cpu_req = 1'b1;
        cpu_wr = wr;
        cpu_be = be;
        cpu_addr = addr;
        cpu_wdata = wd;
        err_expect = !ok;
        @(negedge clk);
        if (!ok) begin
            check("err_nostall", cpu_stall, 0);
            @(posedge clk);
            #1;
            cpu_req = 1'b0;
            @(negedge clk);
            check("err_pulse", cpu_err, 1);
            @(posedge clk);
            #1;
            err_expect = 0;
            return;
        end
        e.we = wr;
        e.addr = {addr[31:2], 2'(lo)};
        e.size = (n == 1) ? 2'b00 : (n == 2) ? 2'b01 : 2'b10;
        e.data = wr ? (wd >> (8 * lo)) : 32'h0;
        if (wr) begin
            t = 0;
            while (cpu_stall && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (cpu_stall) begin
                check("store_timeout", 1, 0);
            end else begin
                exp_q.push_back(e);
                for (int i = 0; i < 4; i++)
                    if (be[i])
                        cpu_mem[{addr[3:2], 2'(i)}] = wd[8*i +: 8];
            end
        end else begin
            check("load_stall", cpu_stall, 1);
            expv = '0;
            for (int i = 0; i < 4; i++)
                if (be[i])
                    expv[8*i +: 8] = cpu_mem[{addr[3:2], 2'(i)}];
            exp_q.push_back(e);
            load_waiting = 1;
            t = 0;
            while (!cpu_rvalid && t < 300) begin
                @(negedge clk);
                t++;
            end
            check("load_rvalid", cpu_rvalid, 1);
            if (cpu_rvalid) begin
                check("load_nostall", cpu_stall, 0);
                check("load_data", cpu_rdata, expv);
                check("load_latency", cyc - acc_cyc, 2);
            end
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        load_waiting = 0;
    endtask

    // Reset with stores buffered and a load held by the CPU.
    task automatic rst_mid(input int nst);
        stall_mode = 2;
        idle(6);
        stall_mode = 1;
        for (int i = 0; i < nst; i++)
            cpu_op(1, 4'hf, 32'h100 + 32'(4 * i), $urandom);
        cpu_req = 1'b1;
        cpu_wr = 1'b0;
        cpu_be = 4'hf;
        cpu_addr = 32'h10c;
        repeat (2) begin
            @(negedge clk);
            check("rst_ld_stall", cpu_stall, 1);
        end
        check("rst_pre_en", sbus.en, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        cpu_mem = slv_mem;
        @(negedge clk);
        check("rst_en", sbus.en, 0);
        stall_mode = 2;
        repeat (4) begin
            @(negedge clk);
            check("rst_flush", {sbus.en, cpu_rvalid}, 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int k, w;
        for (int i = 0; i < 16; i++) begin
            cpu_mem[i] = '0;
            slv_mem[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state",
              {cpu_stall, cpu_rvalid, cpu_rdata,
               cpu_err, sbus.en, sbus.we},
              '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // Single byte store, lane 2.
        cpu_op(1, 4'b0100, 32'h1002, 32'h00ab0000);
        idle(4);
        check("t1_drained", exp_q.size(), 0);

        // Fill the buffer with the bus stalled.
        stall_mode = 1;
        for (int i = 0; i < 4; i++)
            cpu_op(1, 4'hf, 32'h2000 + 32'(4 * i),
                   32'h1111_1111 * (i + 1));
        cpu_req = 1'b1;
        cpu_wr = 1'b1;
        cpu_be = 4'h1;
        cpu_addr = 32'h2010;
        cpu_wdata = 32'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wb_full_stall", cpu_stall, 1);
            if (i == 2) stall_mode = 2;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("full_no_pushthru", cpu_stall, 1);
        @(posedge clk);
        #1;
        cpu_op(1, 4'h1, 32'h2010, 32'h55);
        idle(8);
        check("t2_drained", exp_q.size(), 0);

        // Stores then a halfword load behind them.
        stall_mode = 0;
        cpu_op(1, 4'hf, 32'h2000, 32'h1234_0000);
        cpu_op(1, 4'hf, 32'h2008, 32'hdead_beef);
        cpu_op(0, 4'b1100, 32'h2002, 32'h0);
        check("t3_rdata", cpu_rdata, 32'h1234_0000);

        // Word load with the read stalled.
        stall_mode = 2;
        idle(4);
        stall_mode = 1;
        fork
            cpu_op(0, 4'hf, 32'h2000, 32'h0);
            begin
                repeat (4) @(negedge clk);
                stall_mode = 2;
            end
        join
        check("t4_rdata", cpu_rdata, 32'h1234_0000);

        // Illegal requests.
        cpu_op(1, 4'b0110, 32'h3001, 32'hffff_ffff);
        cpu_op(0, 4'b0011, 32'h3001, 32'h0);
        cpu_op(1, 4'b0000, 32'h3000, 32'h0);
        check("t5_rdata_hold", cpu_rdata, 32'h1234_0000);

        // Reset mid-operation.
        rst_mid(3);
        rst_mid(0);

        // Random mix against the byte-memory model.
        stall_mode = 0;
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 6);
            w = $urandom_range(0, 3);
            case ($urandom % 10)
                0, 1, 2, 3, 4:
                    cpu_op(1, be_tab[k],
                           32'h100 + 32'(4 * w) + 32'(lane_tab[k]),
                           $urandom);
                5, 6, 7, 8:
                    cpu_op(0, be_tab[k],
                           32'h100 + 32'(4 * w) + 32'(lane_tab[k]),
                           32'h0);
                default:
                    cpu_op($urandom % 2 == 1, 4'($urandom),
                           32'h100 + 32'($urandom % 16),
                           $urandom);
            endcase
            if ($urandom % 4 == 0) idle(1);
        end
        stall_mode = 2;
        idle(10);
        check("final_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
